// File: rtl/mstd_sequencer.sv
// Multi-cycle RV M-extension unit: radix-2 shift-add multiply / restoring divide with IDLE/BUSY/DONE control.
// Optional MSTD_PAIR_FUSE_EN keeps the last divide's quotient+remainder so a matching div/rem answers in one cycle.
module mstd_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            KILL,
    input  logic [2:0]      FUN3,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [XLEN-1:0] RS2_DATA,
    output logic            STALL,
    output logic [XLEN-1:0] RESULT,
    output logic            RESULT_VALID
);

    localparam logic [XLEN-1:0]  SMIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        fun3_q, fun3_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]   res_q, res_d;

    // operand decode for a new request
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_q, spec_r, spec_res;

    assign is_div   = FUN3[2];
    assign a_sgn    = (FUN3 == 3'd1) || (FUN3 == 3'd2) || (FUN3 == 3'd4) || (FUN3 == 3'd6);
    assign b_sgn    = (FUN3 == 3'd1) || (FUN3 == 3'd4) || (FUN3 == 3'd6);
    assign a_neg    = a_sgn & RS1_DATA[XLEN-1];
    assign b_neg    = b_sgn & RS2_DATA[XLEN-1];
    assign a_mag    = a_neg ? -RS1_DATA : RS1_DATA;
    assign b_mag    = b_neg ? -RS2_DATA : RS2_DATA;
    assign div_zero = is_div && (RS2_DATA == '0);
    assign div_ovf  = is_div && !FUN3[0] && (RS1_DATA == SMIN) && (RS2_DATA == '1);
    assign spec_q   = div_zero ? '1 : SMIN;
    assign spec_r   = div_zero ? RS1_DATA : '0;
    assign spec_res = FUN3[1] ? spec_r : spec_q;

    // one iteration of the unsigned core; acc = {hi, lo} = {P_hi, multiplier} or {rem, quot}
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, iter_nxt, prod_s;
    logic [XLEN-1:0]   q_fin, r_fin, fin_res;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    assign mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opd_q};
    assign div_nxt  = (div_sh >= {1'b0, opd_q}) ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                                : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    assign iter_nxt = fun3_q[2] ? div_nxt : mul_nxt;

    // sign fix-up on the final iteration: quotient/product by sign xor, remainder follows dividend
    assign prod_s = (sa_q ^ sb_q) ? -iter_nxt : iter_nxt;
    assign q_fin  = (sa_q ^ sb_q) ? -iter_nxt[XLEN-1:0] : iter_nxt[XLEN-1:0];
    assign r_fin  = sa_q ? -iter_nxt[2*XLEN-1:XLEN] : iter_nxt[2*XLEN-1:XLEN];

    always_comb begin
        fin_res = prod_s[2*XLEN-1:XLEN];
        case (fun3_q)
            3'd0:       fin_res = prod_s[XLEN-1:0];
            3'd4, 3'd5: fin_res = q_fin;
            3'd6, 3'd7: fin_res = r_fin;
            default:    fin_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end

`ifdef MSTD_PAIR_FUSE_EN
    logic            fz_vld_q, fz_vld_d, fz_sgn_q, fz_sgn_d;
    logic [XLEN-1:0] fz_a_q, fz_a_d, fz_b_q, fz_b_d, fz_q_q, fz_q_d, fz_r_q, fz_r_d;
    logic [XLEN-1:0] raw_a_q, raw_a_d, raw_b_q, raw_b_d;
    logic            fz_hit;

    assign fz_hit = fz_vld_q && is_div && (RS1_DATA == fz_a_q) && (RS2_DATA == fz_b_q)
                    && (!FUN3[0] == fz_sgn_q);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fun3_d       = fun3_q;
        acc_d        = acc_q;
        opd_d        = opd_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        res_d        = res_q;
        STALL        = 1'b0;
        RESULT_VALID = 1'b0;
`ifdef MSTD_PAIR_FUSE_EN
        fz_vld_d = fz_vld_q;
        fz_sgn_d = fz_sgn_q;
        fz_a_d   = fz_a_q;
        fz_b_d   = fz_b_q;
        fz_q_d   = fz_q_q;
        fz_r_d   = fz_r_q;
        raw_a_d  = raw_a_q;
        raw_b_d  = raw_b_q;
`endif
        if (KILL) begin
            state_d = IDLE;
`ifdef MSTD_PAIR_FUSE_EN
            if (state_q != IDLE && fun3_q[2]) fz_vld_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        STALL  = 1'b1;
                        fun3_d = FUN3;
                        sa_d   = a_neg;
                        sb_d   = b_neg;
                        cnt_d  = '0;
                        opd_d  = is_div ? b_mag : a_mag;
                        acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
`ifdef MSTD_PAIR_FUSE_EN
                        raw_a_d = RS1_DATA;
                        raw_b_d = RS2_DATA;
`endif
                        if (div_zero || div_ovf) begin
                            res_d   = spec_res;
                            state_d = DONE;
`ifdef MSTD_PAIR_FUSE_EN
                            fz_vld_d = 1'b1;
                            fz_sgn_d = !FUN3[0];
                            fz_a_d   = RS1_DATA;
                            fz_b_d   = RS2_DATA;
                            fz_q_d   = spec_q;
                            fz_r_d   = spec_r;
`endif
                        end
`ifdef MSTD_PAIR_FUSE_EN
                        else if (fz_hit) begin
                            res_d   = FUN3[1] ? fz_r_q : fz_q_q;
                            state_d = DONE;
                        end
`endif
                        else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    STALL = 1'b1;
                    acc_d = iter_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_END) begin
                        state_d = DONE;
                        res_d   = fin_res;
`ifdef MSTD_PAIR_FUSE_EN
                        if (fun3_q[2]) begin
                            fz_vld_d = 1'b1;
                            fz_sgn_d = !fun3_q[0];
                            fz_a_d   = raw_a_q;
                            fz_b_d   = raw_b_q;
                            fz_q_d   = q_fin;
                            fz_r_d   = r_fin;
                        end else begin
                            fz_vld_d = 1'b0;
                        end
`endif
                    end
                end
                DONE: begin
                    RESULT_VALID = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fun3_q  <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fun3_q  <= fun3_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
        end
    end

`ifdef MSTD_PAIR_FUSE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fz_vld_q <= 1'b0;
            fz_sgn_q <= 1'b0;
            fz_a_q   <= '0;
            fz_b_q   <= '0;
            fz_q_q   <= '0;
            fz_r_q   <= '0;
            raw_a_q  <= '0;
            raw_b_q  <= '0;
        end else begin
            fz_vld_q <= fz_vld_d;
            fz_sgn_q <= fz_sgn_d;
            fz_a_q   <= fz_a_d;
            fz_b_q   <= fz_b_d;
            fz_q_q   <= fz_q_d;
            fz_r_q   <= fz_r_d;
            raw_a_q  <= raw_a_d;
            raw_b_q  <= raw_b_d;
        end
    end
`endif

    assign RESULT = res_q;

endmodule
